// File: rtl/vtg_pkg.sv
// vtg_pkg: shared definitions for the video timing generator.
//   VTG_CNT_W      : width of counters, config fields and coordinates
//   CFG_* addresses: shadow-register map (H_SYNC..V_FRONT = 0..7)
//   vtg_timing_t   : per-axis timing record (sync, back, disp, front)
//   vtg_total()    : sum of the four phase lengths of one axis
package vtg_pkg;

    localparam int VTG_CNT_W = 12;

    localparam logic [2:0] CFG_H_SYNC  = 3'd0;
    localparam logic [2:0] CFG_H_BACK  = 3'd1;
    localparam logic [2:0] CFG_H_DISP  = 3'd2;
    localparam logic [2:0] CFG_H_FRONT = 3'd3;
    localparam logic [2:0] CFG_V_SYNC  = 3'd4;
    localparam logic [2:0] CFG_V_BACK  = 3'd5;
    localparam logic [2:0] CFG_V_DISP  = 3'd6;
    localparam logic [2:0] CFG_V_FRONT = 3'd7;

    typedef struct packed {
        logic [VTG_CNT_W-1:0] sync;
        logic [VTG_CNT_W-1:0] back;
        logic [VTG_CNT_W-1:0] disp;
        logic [VTG_CNT_W-1:0] front;
    } vtg_timing_t;

    function automatic logic [VTG_CNT_W-1:0] vtg_total(input vtg_timing_t t);
        return t.sync + t.back + t.disp + t.front;
    endfunction

endpackage

// File: rtl/vtg_axis.sv
// vtg_axis: one raster axis. Wrapping position counter plus combinational
// phase decode of the current position.
//   clk, rst : pixel clock, synchronous active-high reset
//   adv      : advance the counter this cycle
//   tim      : live timing for this axis
//   cnt      : current position, 0..total-1
//   is_sync  : position lies in the sync phase
//   is_disp  : position lies in the display phase
//   is_last  : position is the final one of the axis (wrap point)
//   rel      : position relative to display start, 0 outside display
module vtg_axis
    import vtg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  vtg_timing_t          tim,
    output logic [VTG_CNT_W-1:0] cnt,
    output logic                 is_sync,
    output logic                 is_disp,
    output logic                 is_last,
    output logic [VTG_CNT_W-1:0] rel
);

    logic [VTG_CNT_W-1:0] disp_start;
    logic [VTG_CNT_W-1:0] disp_end;
    logic [VTG_CNT_W-1:0] last_pos;

    assign disp_start = tim.sync + tim.back;
    assign disp_end   = disp_start + tim.disp;
    assign last_pos   = vtg_total(tim) - VTG_CNT_W'(1);

    assign is_sync = (cnt < tim.sync);
    assign is_disp = (cnt >= disp_start) && (cnt < disp_end);
    assign is_last = (cnt == last_pos);
    assign rel     = is_disp ? (cnt - disp_start) : '0;

    // Live timing only changes on the frame wrap, when both axes are at
    // their last position, so the counter never sits beyond last_pos.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= is_last ? '0 : cnt + VTG_CNT_W'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: 2-D raster timing generator with frame-synchronous
// reprogrammable timing.
//   clk, rst           : pixel clock, synchronous active-high reset
//   en                 : pixel advance enable
//   cfg_we/addr/data   : shadow-register write (zero data is ignored)
//   cfg_pending        : shadow differs from live config, awaiting commit
//   line_cmp, line_irq : line compare and its pulse (VTG_LINE_IRQ_EN only)
//   h_sync, v_sync     : sync outputs, polarity from H_POL / V_POL
//   de, x, y           : display enable and active-area coordinates
//   eol, eof           : last pixel of line / frame strobes
// All outputs are registered one clock after the position they describe.
// Build option: define VTG_LINE_IRQ_EN to build the line compare logic;
// otherwise line_irq is tied low and line_cmp is ignored.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int   CNT_W   = VTG_CNT_W,
    parameter int   H_SYNC  = 192,
    parameter int   H_BACK  = 96,
    parameter int   H_DISP  = 1280,
    parameter int   H_FRONT = 32,
    parameter int   V_SYNC  = 3,
    parameter int   V_BACK  = 38,
    parameter int   V_DISP  = 1024,
    parameter int   V_FRONT = 1,
    parameter logic H_POL   = 1'b0,
    parameter logic V_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             cfg_pending,
    input  logic [CNT_W-1:0] line_cmp,
    output logic             line_irq,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             eol,
    output logic             eof
);

    // The timing record is sized by the package, so the counter width is
    // tied to it.
    if (CNT_W != VTG_CNT_W) begin : g_bad_cnt_w
        $error("video_timing_gen: CNT_W must equal vtg_pkg::VTG_CNT_W");
    end
    if (H_SYNC + H_BACK + H_DISP + H_FRONT >= (1 << CNT_W)) begin : g_bad_h_tot
        $error("video_timing_gen: default horizontal total does not fit CNT_W");
    end
    if (V_SYNC + V_BACK + V_DISP + V_FRONT >= (1 << CNT_W)) begin : g_bad_v_tot
        $error("video_timing_gen: default vertical total does not fit CNT_W");
    end

    localparam vtg_timing_t DEF_H = '{
        sync:  VTG_CNT_W'(H_SYNC),
        back:  VTG_CNT_W'(H_BACK),
        disp:  VTG_CNT_W'(H_DISP),
        front: VTG_CNT_W'(H_FRONT)
    };
    localparam vtg_timing_t DEF_V = '{
        sync:  VTG_CNT_W'(V_SYNC),
        back:  VTG_CNT_W'(V_BACK),
        disp:  VTG_CNT_W'(V_DISP),
        front: VTG_CNT_W'(V_FRONT)
    };

    vtg_timing_t live_h, live_v, shad_h, shad_v;
    vtg_timing_t live_h_n, live_v_n, shad_h_n, shad_v_n;

    logic [CNT_W-1:0] h_cnt, v_cnt, h_rel, v_rel;
    logic             h_is_sync, h_is_disp, h_last;
    logic             v_is_sync, v_is_disp, v_last;
    logic             commit;

    vtg_axis u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .adv     (en),
        .tim     (live_h),
        .cnt     (h_cnt),
        .is_sync (h_is_sync),
        .is_disp (h_is_disp),
        .is_last (h_last),
        .rel     (h_rel)
    );

    vtg_axis u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .adv     (en & h_last),
        .tim     (live_v),
        .cnt     (v_cnt),
        .is_sync (v_is_sync),
        .is_disp (v_is_disp),
        .is_last (v_last),
        .rel     (v_rel)
    );

    assign commit = en & h_last & v_last;

    // Commit copies the current (pre-write) shadow, so a write landing on
    // the commit cycle stays pending for one more frame.
    always_comb begin
        shad_h_n = shad_h;
        shad_v_n = shad_v;
        if (cfg_we && (cfg_data != '0)) begin
            case (cfg_addr)
                CFG_H_SYNC:  shad_h_n.sync  = cfg_data;
                CFG_H_BACK:  shad_h_n.back  = cfg_data;
                CFG_H_DISP:  shad_h_n.disp  = cfg_data;
                CFG_H_FRONT: shad_h_n.front = cfg_data;
                CFG_V_SYNC:  shad_v_n.sync  = cfg_data;
                CFG_V_BACK:  shad_v_n.back  = cfg_data;
                CFG_V_DISP:  shad_v_n.disp  = cfg_data;
                CFG_V_FRONT: shad_v_n.front = cfg_data;
                default:     shad_h_n       = shad_h;
            endcase
        end
        live_h_n = commit ? shad_h : live_h;
        live_v_n = commit ? shad_v : live_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_h      <= DEF_H;
            live_v      <= DEF_V;
            shad_h      <= DEF_H;
            shad_v      <= DEF_V;
            cfg_pending <= 1'b0;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            eol         <= 1'b0;
            eof         <= 1'b0;
        end else begin
            live_h      <= live_h_n;
            live_v      <= live_v_n;
            shad_h      <= shad_h_n;
            shad_v      <= shad_v_n;
            cfg_pending <= (shad_h_n != live_h_n) || (shad_v_n != live_v_n);
            if (en) begin
                h_sync <= h_is_sync ? H_POL : ~H_POL;
                v_sync <= v_is_sync ? V_POL : ~V_POL;
                de     <= h_is_disp & v_is_disp;
                x      <= (h_is_disp & v_is_disp) ? h_rel : '0;
                y      <= (h_is_disp & v_is_disp) ? v_rel : '0;
                eol    <= h_last;
                eof    <= h_last & v_last;
            end else begin
                eol    <= 1'b0;
                eof    <= 1'b0;
            end
        end
    end

`ifdef VTG_LINE_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            line_irq <= 1'b0;
        end else begin
            line_irq <= en && (h_cnt == '0) && (v_cnt == line_cmp);
        end
    end
`else
    logic unused_line_cmp;
    assign unused_line_cmp = ^line_cmp;
    assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [11:0] cfg_data = '0;
    logic [11:0] line_cmp = 12'd4095;
    logic        cfg_pending, line_irq, h_sync, v_sync, de, eol, eof;
    logic [11:0] x, y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CNT_W(12), .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_pending(cfg_pending), .line_cmp(line_cmp), .line_irq(line_irq),
        .h_sync(h_sync), .v_sync(v_sync), .de(de), .x(x), .y(y),
        .eol(eol), .eof(eof)
    );

    // Reference model: {hs, vs, de, x[11:0], y[11:0], eol, eof, irq, pend}
    int m_h, m_v;
    int def_cfg [8] = '{2, 2, 4, 2, 1, 1, 3, 1};
    int m_live [8];
    int m_shad [8];
    logic [30:0] m_out;
    int line_cmp_i = 4095;
    logic [30:0] sb_q [$];

    function automatic logic [30:0] model_step(input bit r, input bit e, input bit we,
                                               input int a, input int d);
        int ht, vt, hds, vds, xx, yy;
        bit hs, vs, hd, vd, l_eol, l_eof, l_irq, pend;
        int nshad [8];
        if (r) begin
            m_h = 0; m_v = 0;
            m_live = def_cfg; m_shad = def_cfg;
            m_out = {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 4'b0000};
            return m_out;
        end
        ht = m_live[0] + m_live[1] + m_live[2] + m_live[3];
        vt = m_live[4] + m_live[5] + m_live[6] + m_live[7];
        nshad = m_shad;
        if (we && d != 0) nshad[a] = d;
        if (e) begin
            hds = m_live[0] + m_live[1];
            vds = m_live[4] + m_live[5];
            hs = !(m_h < m_live[0]);
            vs = !(m_v < m_live[4]);
            hd = (m_h >= hds) && (m_h < hds + m_live[2]);
            vd = (m_v >= vds) && (m_v < vds + m_live[6]);
            xx = (hd && vd) ? m_h - hds : 0;
            yy = (hd && vd) ? m_v - vds : 0;
            l_eol = (m_h == ht - 1);
            l_eof = l_eol && (m_v == vt - 1);
`ifdef VTG_LINE_IRQ_EN
            l_irq = (m_h == 0) && (m_v == line_cmp_i);
`else
            l_irq = 1'b0;
`endif
            if (l_eol) begin
                m_h = 0;
                if (m_v == vt - 1) begin
                    m_v = 0;
                    m_live = m_shad;
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                m_h = m_h + 1;
            end
            m_out[30:4] = {hs, vs, hd && vd, xx[11:0], yy[11:0]};
            m_out[3:1]  = {l_eol, l_eof, l_irq};
        end else begin
            m_out[3:1] = 3'b000;
        end
        m_shad = nshad;
        pend = 1'b0;
        for (int i = 0; i < 8; i++) if (m_shad[i] != m_live[i]) pend = 1'b1;
        m_out[0] = pend;
        return m_out;
    endfunction

    function automatic logic [30:0] dut_out();
        return {h_sync, v_sync, de, x, y, eol, eof, line_irq, cfg_pending};
    endfunction

    // Drives one clock of stimulus, queues the predicted result, and
    // returns #1 after the active edge so the caller can compare.
    task automatic cycle(input bit r, input bit e, input bit we, input int a, input int d);
        @(negedge clk);
        rst = r; en = e; cfg_we = we;
        cfg_addr = a[2:0]; cfg_data = d[11:0];
        line_cmp = line_cmp_i[11:0];
        sb_q.push_back(model_step(r, e, we, a, d));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [30:0] exp, got;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset cyc %0d got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_basic();
        logic [30:0] exp, got;
        int n_eol, n_eof, n_hs, n_de;
        n_eol = 0; n_eof = 0; n_hs = 0; n_de = 0;
        cycle(1, 0, 0, 0, 0); void'(sb_q.pop_front());
        for (int i = 0; i < 120; i++) begin
            cycle(0, 1, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic cyc %0d got %h exp %h", i, got, exp);
            end
            if (i < 60) begin
                n_eol += int'(eol); n_eof += int'(eof);
                n_hs += int'(!h_sync); n_de += int'(de);
            end
        end
        checks++;
        if (n_eol != 6) begin errors++; $display("FAIL basic_eol_count got %0d exp 6", n_eol); end
        checks++;
        if (n_eof != 1) begin errors++; $display("FAIL basic_eof_count got %0d exp 1", n_eof); end
        checks++;
        if (n_hs != 12) begin errors++; $display("FAIL basic_hsync_low got %0d exp 12", n_hs); end
        checks++;
        if (n_de != 12) begin errors++; $display("FAIL basic_de_count got %0d exp 12", n_de); end
    endtask

    task automatic test_reset_mid_line();
        logic [30:0] exp, got;
        cycle(1, 0, 0, 0, 0); void'(sb_q.pop_front());
        for (int i = 0; i < 5; i++) begin cycle(0, 1, 0, 0, 0); void'(sb_q.pop_front()); end
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      cycle(1, 1, 0, 0, 0);
            else if (i == 1) cycle(0, 0, 0, 0, 0);
            else             cycle(0, 1, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_line step %0d got %h exp %h", i, got, exp);
            end
        end
        checks++;
        if (h_sync !== 1'b0 || v_sync !== 1'b0 || eol !== 1'b0) begin
            errors++;
            $display("FAIL first_pos got hs=%b vs=%b eol=%b exp hs=0 vs=0 eol=0", h_sync, v_sync, eol);
        end
    endtask

    task automatic test_en_toggle();
        logic [30:0] exp, got;
        int n_eol;
        bit bad;
        n_eol = 0; bad = 0;
        cycle(1, 0, 0, 0, 0); void'(sb_q.pop_front());
        for (int i = 0; i < 80; i++) begin
            cycle(0, (i % 2) == 0, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL en_toggle cyc %0d got %h exp %h", i, got, exp);
            end
            if (i < 40) n_eol += int'(eol);
            if ((i % 2) == 1 && eol) bad = 1;
        end
        checks++;
        if (n_eol != 2) begin errors++; $display("FAIL en_toggle_period got %0d eol exp 2", n_eol); end
        checks++;
        if (bad) begin errors++; $display("FAIL en_toggle_eol_while_idle got 1 exp 0"); end
    endtask

    task automatic test_cfg_write();
        logic [30:0] exp, got;
        int n_de, n_eol;
        bit seen;
        cycle(1, 0, 0, 0, 0); void'(sb_q.pop_front());
        for (int i = 0; i < 25; i++) begin cycle(0, 1, 0, 0, 0); void'(sb_q.pop_front()); end
        cycle(0, 1, 1, 2, 6);
        exp = sb_q.pop_front(); got = dut_out();
        checks++;
        if (got !== exp || cfg_pending !== 1'b1) begin
            errors++;
            $display("FAIL cfg_write_pending got %h exp %h", got, exp);
        end
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle(0, 1, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cfg_write_pre cyc %0d got %h exp %h", i, got, exp);
            end
            if (eof) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL cfg_write_timeout got no eof exp eof"); end
        checks++;
        if (cfg_pending !== 1'b0) begin
            errors++; $display("FAIL cfg_write_commit got pending=%b exp 0", cfg_pending);
        end
        n_de = 0; n_eol = 0;
        for (int i = 0; i < 72; i++) begin
            cycle(0, 1, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cfg_write_post cyc %0d got %h exp %h", i, got, exp);
            end
            n_de += int'(de); n_eol += int'(eol);
        end
        checks++;
        if (n_de != 18) begin errors++; $display("FAIL cfg_write_de got %0d exp 18", n_de); end
        checks++;
        if (n_eol != 6) begin errors++; $display("FAIL cfg_write_htot got %0d eol exp 6", n_eol); end
    endtask

    task automatic test_cfg_zero();
        logic [30:0] exp, got;
        int n_hs;
        n_hs = 0;
        cycle(1, 0, 0, 0, 0); void'(sb_q.pop_front());
        for (int i = 0; i < 60; i++) begin
            if (i == 0) cycle(0, 1, 1, 0, 0);
            else        cycle(0, 1, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp || cfg_pending !== 1'b0) begin
                errors++;
                $display("FAIL cfg_zero cyc %0d got %h exp %h", i, got, exp);
            end
            n_hs += int'(!h_sync);
        end
        checks++;
        if (n_hs != 12) begin errors++; $display("FAIL cfg_zero_hsync got %0d exp 12", n_hs); end
    endtask

    task automatic test_back_to_back();
        logic [30:0] exp, got;
        int n_de;
        cycle(1, 0, 0, 0, 0); void'(sb_q.pop_front());
        for (int i = 0; i < 59; i++) begin cycle(0, 1, 0, 0, 0); void'(sb_q.pop_front()); end
        cycle(0, 1, 1, 2, 6);
        exp = sb_q.pop_front(); got = dut_out();
        checks++;
        if (got !== exp || cfg_pending !== 1'b1 || eof !== 1'b1) begin
            errors++;
            $display("FAIL commit_write got %h exp %h", got, exp);
        end
        n_de = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(0, 1, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL commit_old_frame cyc %0d got %h exp %h", i, got, exp);
            end
            n_de += int'(de);
        end
        checks++;
        if (n_de != 12 || cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL commit_deferred got de=%0d pend=%b exp de=12 pend=0", n_de, cfg_pending);
        end
        n_de = 0;
        for (int i = 0; i < 72; i++) begin
            cycle(0, 1, 0, 0, 0);
            exp = sb_q.pop_front(); got = dut_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL commit_new_frame cyc %0d got %h exp %h", i, got, exp);
            end
            n_de += int'(de);
        end
        checks++;
        if (n_de != 18) begin errors++; $display("FAIL commit_new_de got %0d exp 18", n_de); end
    endtask

    task automatic test_line_irq();
        logic [30:0] exp, got;
        int n_irq, exp_irq;
`ifdef VTG_LINE_IRQ_EN
        exp_irq = 2;
`else
        exp_irq = 0;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            line_cmp_i = (pass == 0) ? 3 : 9;
            n_irq = 0;
            cycle(1, 0, 0, 0, 0); void'(sb_q.pop_front());
            for (int i = 0; i < 120; i++) begin
                cycle(0, 1, 0, 0, 0);
                exp = sb_q.pop_front(); got = dut_out();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL line_irq pass %0d cyc %0d got %h exp %h", pass, i, got, exp);
                end
                n_irq += int'(line_irq);
            end
            checks++;
            if (n_irq != ((pass == 0) ? exp_irq : 0)) begin
                errors++;
                $display("FAIL line_irq_count pass %0d got %0d exp %0d",
                         pass, n_irq, (pass == 0) ? exp_irq : 0);
            end
        end
        line_cmp_i = 4095;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_line();
        test_en_toggle();
        test_cfg_write();
        test_cfg_zero();
        test_back_to_back();
        test_line_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Full 2-D raster timing generator and successor to the single-axis sync generator.
- Produces horizontal and vertical sync, display-enable, active-area pixel coordinates and line/frame strobes from one pixel clock.
- Timing is runtime-reprogrammable through shadow registers that commit only at frame boundaries.
- Sits between the pixel-clock domain and the frame-buffer reader / panel output stage.

Parameters:
- CNT_W, 12: width of the internal counters, config data and coordinate outputs.
- H_SYNC, 192: default horizontal sync width, in pixels.
- H_BACK, 96: default horizontal back porch.
- H_DISP, 1280: default active pixels per line.
- H_FRONT, 32: default horizontal front porch.
- V_SYNC, 3: default vertical sync width, in lines.
- V_BACK, 38: default vertical back porch.
- V_DISP, 1024: default active lines.
- V_FRONT, 1: default vertical front porch.
- H_POL, 0: asserted level of h_sync (0 = active-low pulse).
- V_POL, 0: asserted level of v_sync.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- en  in  1  pixel advance enable
- cfg_we  in  1  shadow-register write strobe
- cfg_addr  in  3  0..7 = H_SYNC, H_BACK, H_DISP, H_FRONT, V_SYNC, V_BACK, V_DISP, V_FRONT
- cfg_data  in  CNT_W  value to write
- cfg_pending  out  1  shadow differs from live config, awaiting commit
- line_cmp  in  CNT_W  compare line (optional feature only)
- line_irq  out  1  compare pulse (optional feature only)
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- de  out  1  display enable
- x  out  CNT_W  active-area column, 0 when de=0
- y  out  CNT_W  active-area row, 0 when de=0
- eol  out  1  last pixel of line strobe
- eof  out  1  last pixel of frame strobe

Behaviour:
- Totals: H_TOT = sum of the four H fields; V_TOT likewise. h_cnt runs 0..H_TOT-1; v_cnt advances when h_cnt wraps and runs 0..V_TOT-1.
- Phase order per axis: sync, back porch, display, front porch. Sync is asserted for cnt < SYNC.
- Display: de=1 when SYNC+BACK <= h_cnt < SYNC+BACK+DISP and the same condition holds on v_cnt. Then x = h_cnt-H_SYNC-H_BACK and y = v_cnt-V_SYNC-V_BACK.
- All outputs are registered and describe the counter position with exactly one clock of latency. They are mutually aligned.
- Reset state:
  - h_cnt = v_cnt = 0.
  - h_sync = ~H_POL, v_sync = ~V_POL.
  - de, eol, eof, line_irq, cfg_pending = 0; x = y = 0.
  - Live and shadow config = parameter defaults.
- en=0: counters and level outputs hold. eol, eof and line_irq are registered 0. Config writes are still accepted.
- eol: one-cycle pulse for position h_cnt = H_TOT-1 while en=1.
- eof: pulse when, additionally, v_cnt = V_TOT-1.
- Config write rules:
  - A cfg_we write updates the shadow register in the next cycle.
  - Writing 0 is ignored and the shadow is left unchanged.
  - cfg_pending rises the cycle after a write that changes the shadow.
- Commit: on the enabled wrap from (H_TOT-1, V_TOT-1) to (0,0), the shadow copies to live config and cfg_pending clears. Never mid-frame.
- Write coinciding with commit: the commit uses the pre-write shadow. The new value stays pending until the next frame.
- Reset mid-frame: counters return to 0, live config returns to defaults and pending writes are discarded.
- Width rule: elaboration error if a default total ≥ 2^CNT_W. Runtime totals overflowing CNT_W are undefined; software is responsible.

Optional Feature:
- Macro VTG_LINE_IRQ_EN.
- Defined: line_irq pulses one cycle, aligned with the other outputs, for position (h_cnt=0, v_cnt=line_cmp) while en=1. line_cmp ≥ V_TOT never fires.
- Undefined: line_irq is tied 0, line_cmp is ignored, and no compare logic is built. Ports stay present for interface stability.

Decomposition:
- Package vtg_pkg holds CNT_W default, cfg_addr constants (CFG_H_SYNC..CFG_V_FRONT) and the 4-field timing record type.
- One sub-module, vtg_axis: a counter with wrap, phase decode (sync/display/last) and relative coordinate. Instantiated twice.
  - The H instance increments on en.
  - The V instance increments on the H wrap.

Test Plan:
- Small timing (H 2/2/4/2 → H_TOT=10; V 1/1/3/1 → V_TOT=6), en=1 held after reset:
  - h_sync low for 2 of every 10 cycles.
  - de high 4 cycles per line on lines 2..4, with x 0..3 and y 0..2.
  - eol every 10 cycles; eof every 60.
- Reset mid-line at h_cnt=5: next cycle all outputs at reset values. The first enabled cycle after release shows position (0,0) one clock later.
- en toggled 1/0 every cycle: line period doubles to 20 clocks. Outputs hold during en=0 and eol never asserts while en=0.
- Write cfg_addr=2 data=6 mid-frame:
  - cfg_pending=1 next cycle.
  - de width stays 4 until the eof wrap, then becomes 6 with H_TOT=12.
  - cfg_pending=0 after commit.
- Write data=0 to addr 0: ignored, cfg_pending stays 0, timing unchanged. Write coinciding with the commit cycle takes effect one frame later.
- With VTG_LINE_IRQ_EN, line_cmp=3: exactly one line_irq pulse per frame, aligned with h=0 of line 3. line_cmp=9 never fires. Without the macro, line_irq is constant 0.
